// File: rtl/main_memory_pkg.sv
// main_memory_pkg: default geometry and FSM state encoding for main_memory.
package main_memory_pkg;
  localparam int DATA_W_DEF = 13;
  localparam int ADDR_W_DEF = 13;
  localparam int DEPTH_DEF = 256;
  localparam int ACCESS_CYCLES_DEF = 1;
  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t BUSY = 1'b1;
endpackage

// File: rtl/mem_bank.sv
// mem_bank: single-port DEPTH x DATA_W array, synchronous write, combinational read.
// Contents rely on the RAM power-up state of zero and are never reset.
module mem_bank #(
  parameter int DATA_W = 13,
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;
  assign rdata = mem[idx];
endmodule

// File: rtl/main_memory.sv
// main_memory: split instruction/data memory with fixed multi-cycle access and a Done pulse.
// Define MAIN_MEMORY_IMEM_WRITE_PROTECT_EN to make the instruction space read-only.
module main_memory
  import main_memory_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  input  logic              write,
  input  logic              read,
  input  logic              instruction,
  output logic              Done
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [DATA_W-1:0] din_l, irdata, drdata;
  logic instr_l, wr_l, fin, iwe, dwe, unused_addr;
  assign unused_addr = ^address;
  // a held-low reset suppresses completion so an aborted access never reaches the arrays
  assign fin = reset && state == BUSY && cnt == CNT_W'(1);
  assign dwe = fin && wr_l && !instr_l;
`ifdef MAIN_MEMORY_IMEM_WRITE_PROTECT_EN
  assign iwe = 1'b0;
`else
  assign iwe = fin && wr_l && instr_l;
`endif
  mem_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_imem (
    .clk(clk), .we(iwe), .idx(idx), .wdata(din_l), .rdata(irdata)
  );
  mem_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_dmem (
    .clk(clk), .we(dwe), .idx(idx), .wdata(din_l), .rdata(drdata)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      Done <= 1'b0;
      dataOut <= '0;
    end else begin
      Done <= fin;
      if (state == IDLE) begin
        if (read || write) begin
          state <= BUSY;
          cnt <= CNT_W'(ACCESS_CYCLES);
          idx <= address[IDX_W-1:0];
          din_l <= dataIn;
          instr_l <= instruction;
          wr_l <= write;
        end
      end else if (fin) begin
        state <= IDLE;
        cnt <= '0;
        if (!wr_l) dataOut <= instr_l ? irdata : drdata;
      end else
        cnt <= cnt - CNT_W'(1);
    end
endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory: directed self-checking bench for main_memory (ACCESS_CYCLES = 2).
module tb_main_memory;
  localparam int ACC = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [12:0] address = '0;
  logic [12:0] dataIn = '0;
  logic [12:0] dataOut;
  logic write = 1'b0;
  logic read = 1'b0;
  logic instruction = 1'b0;
  logic Done;
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  main_memory #(.DATA_W(13), .ADDR_W(13), .DEPTH(256), .ACCESS_CYCLES(ACC)) dut (
    .clk(clk), .reset(reset), .address(address), .dataIn(dataIn), .dataOut(dataOut),
    .write(write), .read(read), .instruction(instruction), .Done(Done)
  );

  // Drives one request for a single edge and returns the edges until Done (-1 on timeout).
  task automatic issue(input logic rd, input logic wr, input logic ins,
                       input logic [12:0] a, input logic [15:0] d, output int lat);
    read = rd; write = wr; instruction = ins; address = a; dataIn = d[12:0];
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    lat = 0;
    while (Done !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    if (Done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    @(posedge clk); #1;
    total++; if (Done !== 1'b0) $display("FAIL reset_done: got %b want 0", Done); else passed++;
    reset = 1'b1;
    repeat (3) @(posedge clk); #1;
    total++; if (Done !== 1'b0) $display("FAIL idle_done: got %b want 0", Done); else passed++;
    total++; if (dataOut !== 13'h0) $display("FAIL reset_dataout: got %h want 0000", dataOut); else passed++;
  endtask

  task automatic test_read_powerup;
    int lat;
    issue(1'b1, 1'b0, 1'b0, 13'h0, 16'h0, lat);
    total++; if (lat !== ACC) $display("FAIL pwr_read_latency: got %0d want %0d", lat, ACC); else passed++;
    total++; if (dataOut !== 13'h0) $display("FAIL pwr_read_data: got %h want 0000", dataOut); else passed++;
    @(posedge clk); #1;
    total++; if (Done !== 1'b0) $display("FAIL done_one_cycle: got %b want 0", Done); else passed++;
  endtask

  task automatic test_write_read;
    int lat;
    issue(1'b0, 1'b1, 1'b0, 13'h0, 16'hF0F0, lat);
    total++; if (lat !== ACC) $display("FAIL write_latency: got %0d want %0d", lat, ACC); else passed++;
    total++; if (dataOut !== 13'h0) $display("FAIL write_keeps_dataout: got %h want 0000", dataOut); else passed++;
    issue(1'b1, 1'b0, 1'b0, 13'h0, 16'h0, lat);
    total++; if (dataOut !== 13'h10F0) $display("FAIL dmem_readback: got %h want 10f0", dataOut); else passed++;
    issue(1'b1, 1'b0, 1'b1, 13'h0, 16'h0, lat);
    total++; if (dataOut !== 13'h0) $display("FAIL imem_independent: got %h want 0000", dataOut); else passed++;
  endtask

  task automatic test_read_write_both;
    int lat;
    issue(1'b1, 1'b0, 1'b0, 13'h0, 16'h0, lat);
    issue(1'b1, 1'b1, 1'b0, 13'h5, 16'h0ABC, lat);
    total++; if (lat !== ACC) $display("FAIL rw_latency: got %0d want %0d", lat, ACC); else passed++;
    total++; if (dataOut !== 13'h10F0) $display("FAIL rw_dataout_held: got %h want 10f0", dataOut); else passed++;
    issue(1'b1, 1'b0, 1'b0, 13'h5, 16'h0, lat);
    total++; if (dataOut !== 13'h0ABC) $display("FAIL rw_is_write: got %h want 0abc", dataOut); else passed++;
  endtask

  task automatic test_alias;
    int lat;
    issue(1'b1, 1'b0, 1'b0, 13'h0105, 16'h0, lat);
    total++; if (dataOut !== 13'h0ABC) $display("FAIL alias_read: got %h want 0abc", dataOut); else passed++;
    issue(1'b0, 1'b1, 1'b0, 13'h1F07, 16'h0777, lat);
    issue(1'b1, 1'b0, 1'b0, 13'h0007, 16'h0, lat);
    total++; if (dataOut !== 13'h0777) $display("FAIL alias_write: got %h want 0777", dataOut); else passed++;
  endtask

  task automatic test_busy_ignore;
    int lat;
    read = 1'b0; write = 1'b1; instruction = 1'b0; address = 13'h9; dataIn = 13'h0111;
    @(posedge clk); #1;
    read = 1'b1; write = 1'b1; instruction = 1'b1; address = 13'hA; dataIn = 13'h1FFF;
    lat = 0;
    while (Done !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    read = 1'b0; write = 1'b0; instruction = 1'b0;
    total++; if (lat !== ACC) $display("FAIL busy_latency: got %0d want %0d", lat, ACC); else passed++;
    issue(1'b1, 1'b0, 1'b0, 13'h9, 16'h0, lat);
    total++; if (dataOut !== 13'h0111) $display("FAIL busy_latched_write: got %h want 0111", dataOut); else passed++;
    issue(1'b1, 1'b0, 1'b1, 13'hA, 16'h0, lat);
    total++; if (dataOut !== 13'h0) $display("FAIL busy_ignored_write: got %h want 0000", dataOut); else passed++;
  endtask

  task automatic test_back_to_back;
    int lat;
    issue(1'b0, 1'b1, 1'b0, 13'h20, 16'h0042, lat);
    issue(1'b0, 1'b1, 1'b0, 13'h21, 16'h0043, lat);
    total++; if (lat !== ACC) $display("FAIL b2b_latency: got %0d want %0d", lat, ACC); else passed++;
    issue(1'b1, 1'b0, 1'b0, 13'h20, 16'h0, lat);
    issue(1'b1, 1'b0, 1'b0, 13'h21, 16'h0, lat);
    total++; if (dataOut !== 13'h0043) $display("FAIL b2b_data: got %h want 0043", dataOut); else passed++;
  endtask

  task automatic test_reset_busy;
    int lat;
    logic seen;
    write = 1'b1; instruction = 1'b0; address = 13'h3; dataIn = 13'h1234;
    @(posedge clk); #1;
    write = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    total++; if (dataOut !== 13'h0) $display("FAIL reset_busy_dataout: got %h want 0000", dataOut); else passed++;
    reset = 1'b1;
    seen = Done;
    repeat (4) begin
      @(posedge clk); #1;
      seen |= Done;
    end
    total++; if (seen !== 1'b0) $display("FAIL reset_busy_no_done: got %b want 0", seen); else passed++;
    issue(1'b1, 1'b0, 1'b0, 13'h3, 16'h0, lat);
    total++; if (dataOut !== 13'h0) $display("FAIL reset_busy_no_write: got %h want 0000", dataOut); else passed++;
  endtask

  task automatic test_imem_write;
    int lat;
    logic [12:0] exp;
`ifdef MAIN_MEMORY_IMEM_WRITE_PROTECT_EN
    exp = 13'h0;
`else
    exp = 13'h0155;
`endif
    issue(1'b0, 1'b1, 1'b1, 13'h3, 16'h0155, lat);
    total++; if (lat !== ACC) $display("FAIL imem_write_done: got %0d want %0d", lat, ACC); else passed++;
    issue(1'b1, 1'b0, 1'b1, 13'h3, 16'h0, lat);
    total++; if (dataOut !== exp) $display("FAIL imem_readback: got %h want %h", dataOut, exp); else passed++;
    issue(1'b1, 1'b0, 1'b0, 13'h3, 16'h0, lat);
    total++; if (dataOut !== 13'h0) $display("FAIL dmem_untouched: got %h want 0000", dataOut); else passed++;
  endtask

  initial begin
    test_reset();
    test_read_powerup();
    test_write_read();
    test_read_write_both();
    test_alias();
    test_busy_ignore();
    test_back_to_back();
    test_reset_busy();
    test_imem_write();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
